// File: rtl/ex_lsu_axi.sv
// EX-stage load/store unit: one AXI4-Lite single-beat access per memory op.
// Stalls the pipeline until the access completes, then returns extended load data.
module ex_lsu_axi #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read_ram_i,
  input  logic          write_ram_i,
  input  logic [31:0]   inst_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [4:0]    rd_addr_i,
  output logic          hold_req_o,
  output logic          ld_valid_o,
  output logic [DW-1:0] ld_data_o,
  output logic [4:0]    rd_addr_o,
  output logic          err_o,
  output logic [AW-1:0] m_araddr_o,
  output logic          m_arvalid_o,
  input  logic          m_arready_i,
  input  logic [DW-1:0] m_rdata_i,
  input  logic [1:0]    m_rresp_i,
  input  logic          m_rvalid_i,
  output logic          m_rready_o,
  output logic [AW-1:0] m_awaddr_o,
  output logic          m_awvalid_o,
  input  logic          m_awready_i,
  output logic [DW-1:0] m_wdata_o,
  output logic [DW/8-1:0] m_wstrb_o,
  output logic          m_wvalid_o,
  input  logic          m_wready_i,
  input  logic [1:0]    m_bresp_i,
  input  logic          m_bvalid_i,
  output logic          m_bready_o
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WREQ, WRESP, DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic [DW-1:0] wdata_q;

  logic [2:0]    f3_i;
  logic          req_mis;
  logic [5:0]    sh;
  logic [DW-1:0] t;
  logic [DW-1:0] ld_ext;
  logic          aw_done;
  logic          w_done;
  logic          unused;

  assign f3_i   = inst_i[14:12];
  assign unused = ^{inst_i[31:15], inst_i[11:0]};
  assign sh     = {addr_q[2:0], 3'b000};

  assign m_araddr_o = {addr_q[AW-1:3], 3'b000};
  assign m_awaddr_o = {addr_q[AW-1:3], 3'b000};
  assign m_wdata_o  = wdata_q << sh;

  assign aw_done = !m_awvalid_o || m_awready_i;
  assign w_done  = !m_wvalid_o || m_wready_i;

  always_comb begin
    req_mis = 1'b0;
    unique case (f3_i[1:0])
      2'd0: req_mis = 1'b0;
      2'd1: req_mis = addr_i[0];
      2'd2: req_mis = |addr_i[1:0];
      default: req_mis = |addr_i[2:0];
    endcase
  end

  always_comb begin
    m_wstrb_o = '0;
    unique case (f3_q[1:0])
      2'd0: m_wstrb_o = 8'h01 << addr_q[2:0];
      2'd1: m_wstrb_o = 8'h03 << addr_q[2:0];
      2'd2: m_wstrb_o = 8'h0F << addr_q[2:0];
      default: m_wstrb_o = 8'hFF;
    endcase
  end

  // Lane extraction uses the latched address, data straight off R.
  always_comb begin
    t      = m_rdata_i >> sh;
    ld_ext = t;
    unique case (f3_q)
      3'd0: ld_ext = {{56{t[7]}}, t[7:0]};
      3'd1: ld_ext = {{48{t[15]}}, t[15:0]};
      3'd2: ld_ext = {{32{t[31]}}, t[31:0]};
      3'd4: ld_ext = {56'd0, t[7:0]};
      3'd5: ld_ext = {48'd0, t[15:0]};
      3'd6: ld_ext = {32'd0, t[31:0]};
      default: ld_ext = t;
    endcase
  end

  always_comb begin
    hold_req_o = 1'b0;
    unique case (state)
      IDLE: hold_req_o = read_ram_i || write_ram_i;
      DONE: hold_req_o = 1'b0;
      default: hold_req_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      m_arvalid_o <= 1'b0;
      m_rready_o  <= 1'b0;
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_bready_o  <= 1'b0;
      ld_valid_o  <= 1'b0;
      err_o       <= 1'b0;
      ld_data_o   <= '0;
      rd_addr_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (read_ram_i || write_ram_i) begin
            addr_q  <= addr_i;
            f3_q    <= f3_i;
            rd_q    <= rd_addr_i;
            wdata_q <= wdata_i;
            if (req_mis) begin
              state <= DONE;
              err_o <= 1'b1;
            end else if (read_ram_i) begin
              state       <= RADDR;
              m_arvalid_o <= 1'b1;
            end else begin
              state       <= WREQ;
              m_awvalid_o <= 1'b1;
              m_wvalid_o  <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: begin
          if (m_rvalid_i) begin
            m_rready_o <= 1'b0;
            ld_data_o  <= ld_ext;
            rd_addr_o  <= rd_q;
            ld_valid_o <= (m_rresp_i == 2'b00);
            err_o      <= (m_rresp_i != 2'b00);
            state      <= DONE;
          end
        end
        WREQ: begin
          // AW and W retire independently; leave once both have.
          if (m_awready_i) m_awvalid_o <= 1'b0;
          if (m_wready_i)  m_wvalid_o  <= 1'b0;
          if (aw_done && w_done) begin
            m_bready_o <= 1'b1;
            state      <= WRESP;
          end
        end
        WRESP: begin
          if (m_bvalid_i) begin
            m_bready_o <= 1'b0;
            err_o      <= (m_bresp_i != 2'b00);
            state      <= DONE;
          end
        end
        DONE: begin
          ld_valid_o <= 1'b0;
          err_o      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_lsu_axi.sv
// Bench for ex_lsu_axi: directed table, reset-abort sequence and
// random accesses against a byte-level reference model with a reactive slave.
module tb_ex_lsu_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_ram_i, write_ram_i;
  logic [31:0] inst_i, addr_i;
  logic [63:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        hold_req_o, ld_valid_o, err_o;
  logic [63:0] ld_data_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] m_araddr_o, m_awaddr_o;
  logic        m_arvalid_o, m_arready_i;
  logic [63:0] m_rdata_i;
  logic [1:0]  m_rresp_i, m_bresp_i;
  logic        m_rvalid_i, m_rready_o;
  logic        m_awvalid_o, m_awready_i;
  logic [63:0] m_wdata_o;
  logic [7:0]  m_wstrb_o;
  logic        m_wvalid_o, m_wready_i;
  logic        m_bvalid_i, m_bready_o;

  always #5 clk = ~clk;

  ex_lsu_axi #(.AW(32), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .read_ram_i(read_ram_i), .write_ram_i(write_ram_i),
    .inst_i(inst_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rd_addr_i(rd_addr_i),
    .hold_req_o(hold_req_o), .ld_valid_o(ld_valid_o),
    .ld_data_o(ld_data_o), .rd_addr_o(rd_addr_o), .err_o(err_o),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o),
    .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
    .m_bready_o(m_bready_o)
  );

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          ard, rdl, awd, wd, bd;
    logic        exp_ldv;
    logic        exp_err;
    logic [63:0] exp_data;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w,
      input logic [2:0] f3, input logic [31:0] a,
      input logic [63:0] wd, input logic [63:0] rdat,
      input logic [1:0] rr, input logic [1:0] br,
      input logic el, input logic ee, input logic [63:0] ed,
      input logic [7:0] es, input logic [63:0] ew);
    vec_t v;
    v.rd_en = r; v.wr_en = w; v.f3 = f3; v.addr = a;
    v.wdata = wd; v.rdata = rdat; v.rresp = rr; v.bresp = br;
    v.ard = 0; v.rdl = 0; v.awd = 0; v.wd = 0; v.bd = 0;
    v.exp_ldv = el; v.exp_err = ee; v.exp_data = ed;
    v.exp_strb = es; v.exp_wdata = ew;
    return v;
  endfunction

  // Reference: access size in bytes and byte-granular lane arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[2:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] ld_model(input logic [2:0] f3,
      input logic [31:0] a, input logic [63:0] rdat);
    logic [63:0] r = '0;
    int n = nbytes(f3);
    int off = int'(a[2:0]);
    for (int i = 0; i < 8; i++)
      if (i < n && off + i < 8) r[i*8 +: 8] = rdat[(off+i)*8 +: 8];
    if (!f3[2] && n < 8 && r[n*8-1])
      for (int b = n * 8; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] strb_model(input logic [2:0] f3,
      input logic [31:0] a);
    logic [7:0] s = '0;
    int off = int'(a[2:0]);
    for (int i = 0; i < nbytes(f3); i++)
      if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] wd_model(input logic [31:0] a,
      input logic [63:0] wd);
    logic [63:0] r = '0;
    int off = int'(a[2:0]);
    for (int j = 0; j < 8; j++)
      if (j >= off) r[j*8 +: 8] = wd[(j-off)*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    read_ram_i = 0; write_ram_i = 0; inst_i = '0; addr_i = '0;
    wdata_i = '0; rd_addr_i = '0;
    m_arready_i = 0; m_rdata_i = '0; m_rresp_i = '0; m_rvalid_i = 0;
    m_awready_i = 0; m_wready_i = 0; m_bresp_i = '0; m_bvalid_i = 0;
  endtask

  task automatic run(input vec_t v, input logic [4:0] rd, input string nm);
    int cyc = 0, ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    bit ar_ok = 0, r_ok = 0, aw_ok = 0, w_ok = 0, b_ok = 0, fin = 0;
    int ldv_n = 0, err_n = 0, hold_n = 0, early = 0;
    int ar_seen = 0, aw_seen = 0;
    logic [63:0] got_data = '0, got_wd = '0;
    logic [4:0]  got_rd = '0;
    logic [31:0] got_ara = '0, got_awa = '0;
    logic [7:0]  got_st = '0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      m_arready_i = 0; m_rvalid_i = 0; m_awready_i = 0;
      m_wready_i = 0; m_bvalid_i = 0;
      if (ar_ok && !r_ok) begin
        if (r_c >= v.rdl) begin
          m_rvalid_i = 1; m_rdata_i = v.rdata; m_rresp_i = v.rresp;
          r_ok = m_rready_o;
        end else r_c++;
      end
      if (m_arvalid_o) begin
        ar_seen++;
        if (!ar_ok) begin
          if (ar_c >= v.ard) begin
            m_arready_i = 1; got_ara = m_araddr_o; ar_ok = 1;
          end else ar_c++;
        end
      end
      if (m_bready_o && !(aw_ok && w_ok)) early++;
      if (aw_ok && w_ok && !b_ok) begin
        if (b_c >= v.bd) begin
          m_bvalid_i = 1; m_bresp_i = v.bresp; b_ok = m_bready_o;
        end else b_c++;
      end
      if (m_awvalid_o) begin
        aw_seen++;
        if (!aw_ok) begin
          if (aw_c >= v.awd) begin
            m_awready_i = 1; got_awa = m_awaddr_o; aw_ok = 1;
          end else aw_c++;
        end
      end
      if (m_wvalid_o && !w_ok) begin
        if (w_c >= v.wd) begin
          m_wready_i = 1; got_wd = m_wdata_o; got_st = m_wstrb_o;
          w_ok = 1;
        end else w_c++;
      end
      read_ram_i = v.rd_en; write_ram_i = v.wr_en;
      inst_i = {17'd0, v.f3, 12'h003}; addr_i = v.addr;
      wdata_i = v.wdata; rd_addr_i = rd;
      #1;
      if (ld_valid_o) ldv_n++;
      if (err_o) err_n++;
      if (hold_req_o) hold_n++;
      else begin
        fin = 1; got_data = ld_data_o; got_rd = rd_addr_o;
      end
    end
    if (!fin) chk({nm, "_timeout"}, 64'(cyc), 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    if (ld_valid_o) ldv_n++;
    if (err_o) err_n++;
    chk({nm, "_ldv"}, 64'(ldv_n), 64'(v.exp_ldv));
    chk({nm, "_err"}, 64'(err_n), 64'(v.exp_err));
    if (v.exp_ldv) begin
      chk({nm, "_data"}, got_data, v.exp_data);
      chk({nm, "_rd"}, 64'(got_rd), 64'(rd));
    end
    if (misal(v.f3, v.addr)) begin
      chk({nm, "_hold"}, 64'(hold_n), 64'd1);
      chk({nm, "_nobus"}, 64'(ar_seen + aw_seen), 64'd0);
    end else if (v.rd_en) begin
      chk({nm, "_araddr"}, 64'(got_ara), 64'({v.addr[31:3], 3'b000}));
      chk({nm, "_noaw"}, 64'(aw_seen), 64'd0);
    end else begin
      chk({nm, "_awaddr"}, 64'(got_awa), 64'({v.addr[31:3], 3'b000}));
      chk({nm, "_wdata"}, got_wd, v.exp_wdata);
      chk({nm, "_wstrb"}, 64'(got_st), 64'(v.exp_strb));
      chk({nm, "_bearly"}, 64'(early), 64'd0);
      chk({nm, "_noar"}, 64'(ar_seen), 64'd0);
    end
  endtask

  vec_t tbl[14];

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_ctl", 64'({m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o,
                        m_bready_o, hold_req_o, ld_valid_o, err_o}), 64'd0);
    chk("rst_data", ld_data_o, 64'd0);
    chk("rst_addr", 64'({m_araddr_o, m_awaddr_o, 3'b000, rd_addr_o}), 64'd0);

    tbl[0] = mk(1, 0, 3'd2, 32'h8000_0004, 0, 64'h8000_0001_1234_5678,
                0, 0, 1, 0, 64'hFFFF_FFFF_8000_0001, 0, 0);
    tbl[0].ard = 1; tbl[0].rdl = 1;
    tbl[1] = mk(1, 0, 3'd4, 32'h0000_1003, 0, 64'h0000_0000_F000_0000,
                0, 0, 1, 0, 64'h0000_0000_0000_00F0, 0, 0);
    tbl[2] = mk(1, 0, 3'd0, 32'h0000_1003, 0, 64'h0000_0000_F000_0000,
                0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0);
    tbl[3] = mk(0, 1, 3'd1, 32'h0000_1006, 64'hABCD, 0,
                0, 0, 0, 0, 0, 8'hC0, 64'hABCD_0000_0000_0000);
    tbl[3].wd = 3; tbl[3].bd = 1;
    tbl[4] = mk(1, 0, 3'd2, 32'h0000_1002, 0, 64'h1,
                0, 0, 0, 1, 0, 0, 0);
    tbl[5] = mk(1, 0, 3'd3, 32'h0000_2000, 0, 64'h55,
                2'b10, 0, 0, 1, 0, 0, 0);
    tbl[6] = mk(1, 0, 3'd5, 32'h0000_2002, 0, 64'h0000_0000_8765_0000,
                0, 0, 1, 0, 64'h0000_0000_0000_8765, 0, 0);
    tbl[7] = mk(1, 0, 3'd1, 32'h0000_2002, 0, 64'h0000_0000_8765_0000,
                0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_8765, 0, 0);
    tbl[8] = mk(1, 0, 3'd6, 32'h0000_0004, 0, 64'h89AB_CDEF_0000_0000,
                0, 0, 1, 0, 64'h0000_0000_89AB_CDEF, 0, 0);
    tbl[9] = mk(0, 1, 3'd0, 32'h0000_0005, 64'h11, 0,
                0, 0, 0, 0, 0, 8'h20, 64'h0000_1100_0000_0000);
    tbl[9].awd = 2;
    tbl[10] = mk(0, 1, 3'd3, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 0,
                 0, 0, 0, 0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF);
    tbl[11] = mk(0, 1, 3'd2, 32'h0000_000C, 64'hDEAD_BEEF, 0,
                 0, 2'b10, 0, 1, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    tbl[12] = mk(1, 1, 3'd3, 32'h0000_0010, 64'hFF, 64'h1122_3344_5566_7788,
                 0, 0, 1, 0, 64'h1122_3344_5566_7788, 0, 0);
    tbl[13] = mk(0, 1, 3'd3, 32'h0000_0009, 64'h1, 0,
                 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 14; i++)
      run(tbl[i], 5'(i + 1), $sformatf("vec%0d", i));

    // Abort a load waiting in RDATA with reset, then restart cleanly.
    @(negedge clk);
    read_ram_i = 1; inst_i = {17'd0, 3'd3, 12'h003};
    addr_i = 32'h0000_3000; rd_addr_i = 5'd7;
    @(negedge clk);
    m_arready_i = m_arvalid_o;
    @(negedge clk);
    m_arready_i = 0;
    chk("abort_rready", 64'(m_rready_o), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle_inputs();
    #1;
    chk("abort_ctl", 64'({m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o,
                          m_bready_o, hold_req_o, ld_valid_o, err_o}), 64'd0);
    chk("abort_data", ld_data_o, 64'd0);
    chk("abort_addr", 64'({m_araddr_o, 3'b000, rd_addr_o}), 64'd0);
    begin
      vec_t v;
      v = mk(1, 0, 3'd3, 32'h0000_3000, 0, 64'hCAFE_F00D_1234_5678,
             0, 0, 1, 0, 64'hCAFE_F00D_1234_5678, 0, 0);
      v.rdl = 2;
      run(v, 5'd9, "restart");
    end

    for (int k = 0; k < 40; k++) begin
      vec_t v;
      int n;
      v.rd_en = 1'($urandom % 2);
      v.wr_en = !v.rd_en;
      v.f3 = v.rd_en ? 3'($urandom % 7) : 3'($urandom % 4);
      v.addr = $urandom;
      n = nbytes(v.f3);
      if ($urandom % 5 != 0) v.addr[2:0] = 3'(($urandom % (8 / n)) * n);
      v.wdata = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.rresp = ($urandom % 6 == 0) ? 2'b10 : 2'b00;
      v.bresp = ($urandom % 6 == 0) ? 2'b11 : 2'b00;
      v.ard = $urandom % 4; v.rdl = $urandom % 4;
      v.awd = $urandom % 4; v.wd = $urandom % 4; v.bd = $urandom % 4;
      v.exp_err = misal(v.f3, v.addr) ||
                  (v.rd_en ? v.rresp != 0 : v.bresp != 0);
      v.exp_ldv = v.rd_en && !v.exp_err;
      v.exp_data = ld_model(v.f3, v.addr, v.rdata);
      v.exp_strb = strb_model(v.f3, v.addr);
      v.exp_wdata = wd_model(v.addr, v.wdata);
      run(v, 5'($urandom), $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_lsu_axi.md
Name: ex_lsu_axi

Overview:
- Load/store unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes `read_ram`, `write_ram`, `inst`, the effective address, store data and `rd` from the ID/EX outputs.
- Runs one AXI4-Lite single-beat transaction per memory instruction, 64-bit data bus.
- Holds the pipeline through ctrl until the transaction completes, then returns sign/zero-extended load data for writeback.

Parameters:
- AW, 32, AXI address width.
- DW, 64, AXI data width; fixed at 64, strobe width is DW/8.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- read_ram_i  in  1  EX instruction is a load
- write_ram_i  in  1  EX instruction is a store
- inst_i  in  32  EX instruction; funct3 = inst_i[14:12]
- addr_i  in  AW  effective byte address (base + offset)
- wdata_i  in  64  store data (rs2), right-aligned
- rd_addr_i  in  5  load destination register
- hold_req_o  out  1  stall request to ctrl
- ld_valid_o  out  1  one-cycle pulse: ld_data_o and rd_addr_o valid
- ld_data_o  out  64  extended load result
- rd_addr_o  out  5  latched destination register
- err_o  out  1  one-cycle pulse: misaligned access or non-OKAY response
- m_araddr_o  out  AW  AR address
- m_arvalid_o  out  1  AR valid
- m_arready_i  in  1  AR ready
- m_rdata_i  in  64  R data
- m_rresp_i  in  2  R response
- m_rvalid_i  in  1  R valid
- m_rready_o  out  1  R ready
- m_awaddr_o  out  AW  AW address
- m_awvalid_o  out  1  AW valid
- m_awready_i  in  1  AW ready
- m_wdata_o  out  64  W data
- m_wstrb_o  out  8  W byte strobes
- m_wvalid_o  out  1  W valid
- m_wready_i  in  1  W ready
- m_bresp_i  in  2  B response
- m_bvalid_i  in  1  B valid
- m_bready_o  out  1  B ready

Behaviour:

States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.

Reset (synchronous, rst=1 at a clock edge):
- State goes to IDLE.
- All valid/ready outputs, hold_req_o, ld_valid_o, err_o, ld_data_o, rd_addr_o, and both addresses become 0.
- Reset mid-transaction abandons it; no AXI completion is awaited.

IDLE:
- If read_ram_i: latch addr, funct3 and rd. If read_ram_i and write_ram_i are both 1, the read wins.
  - Misaligned access (half: addr[0]≠0; word: addr[1:0]≠0; double: addr[2:0]≠0): go to DONE with the error flag set; no bus activity.
  - Otherwise go to RADDR.
- Else if write_ram_i: same latching and misalignment check, then go to WREQ.
- m_araddr_o and m_awaddr_o = addr with [2:0] cleared.

hold_req_o:
- Combinational.
- 1 in IDLE when read_ram_i or write_ram_i is 1.
- 1 in RADDR, RDATA, WREQ and WRESP.
- 0 in DONE and otherwise.

RADDR:
- m_arvalid_o=1, held stable until m_arready_i; then go to RDATA.

RDATA:
- m_rready_o=1.
- On m_rvalid_i, capture m_rdata_i and m_rresp_i, then go to DONE.

WREQ:
- m_awvalid_o and m_wvalid_o are asserted together.
- Each channel drops independently after its own handshake (internal aw_done / w_done flags).
- Go to WRESP once both handshakes are done; this may be the same cycle.

WRESP:
- m_bready_o=1.
- On m_bvalid_i, capture m_bresp_i, then go to DONE.

DONE (exactly one cycle, then IDLE):
- hold_req_o=0, so the held instruction advances.
- read_ram_i and write_ram_i are ignored this cycle.
- Load with OKAY response: ld_valid_o=1.
- Misaligned access or resp≠2'b00: err_o=1 and ld_valid_o=0.
- Store: ld_valid_o is always 0.

Store lanes (sh = addr[2:0]*8):
- m_wdata_o = wdata_i << sh.
- m_wstrb_o by funct3:
  - SB: 8'h01<<addr[2:0]
  - SH: 8'h03<<addr[2:0]
  - SW: 8'h0F<<addr[2:0]
  - SD: 8'hFF

Load extraction:
- t = rdata >> sh.
- funct3 0 LB: sign-extend t[7:0].
- funct3 1 LH: sign-extend t[15:0].
- funct3 2 LW: sign-extend t[31:0].
- funct3 3 LD: t.
- funct3 4 LBU, 5 LHU, 6 LWU: zero-extend the same widths.

Holding outputs:
- ld_data_o and rd_addr_o hold their last value outside DONE.

Test Plan:
- LW at addr 0x8000_0004, slave returns rdata 0x8000_0001_xxxx_xxxx with arready/rvalid one cycle late -> araddr 0x8000_0000; hold_req_o high until DONE; ld_valid_o pulse with ld_data_o 0xFFFF_FFFF_8000_0001.
- LBU at addr offset 3, rdata 0x0000_0000_F000_0000 -> ld_data_o 0x0000_0000_0000_00F0; LB of the same -> 0xFFFF_FFFF_FFFF_FFF0.
- SH at addr 0x...06 with wdata 0xABCD, awready 3 cycles before wready -> wstrb 8'hC0; wdata_o[63:48]=0xABCD; bready asserted only after both handshakes; no ld_valid_o.
- LW at addr 0x...02 -> no arvalid ever; err_o pulse in the cycle after the request; hold_req_o high for exactly 1 cycle.
- LD with rresp=2'b10 -> err_o=1, ld_valid_o=0. Separately, rst asserted while in RDATA -> next edge all outputs 0, state IDLE, and a new load restarts cleanly.
